bus_slave_responder: RTL and testbench

Slave-side responder for the two-master / two-slave shared bus. It answers transfers that the bus controller steers to it and drives the ready, response and split signals that the controller samples. It holds a local word memory and inserts programmable wait states. It returns ERROR for out-of-range addresses, SPLIT for slow-region accesses and RETRY while a split is outstanding. One instance sits behind each slave select (slave 1, slave 2).

---
 rtl/bus_slave_responder_if.sv | 32 +++
 rtl/bus_slave_responder.sv | 201 ++++++++++++++++++++
 tb/tb_bus_slave_responder.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/bus_slave_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : bus_slave_responder_if
// Brief    : Controller-to-slave transfer signals for one slave select.
// Revision : 1.0
// ============================================================================
interface bus_slave_responder_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              sel;
    logic              master_id;
    logic              read_write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;
    logic [1:0]        response;
    logic              split;
    logic              split_master;

    modport master (
        output sel, master_id, read_write, addr, wdata,
        input  rdata, ready, response, split, split_master
    );

    modport slave (
        input  sel, master_id, read_write, addr, wdata,
        output rdata, ready, response, split, split_master
    );
endinterface
`default_nettype wire

// File: rtl/bus_slave_responder.sv
`default_nettype none
// ============================================================================
// Module   : bus_slave_responder
// Brief    : Shared-bus slave with local memory, wait states, ERROR/SPLIT/RETRY.
// Revision : 1.0
// ============================================================================
module bus_slave_responder #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int MEM_DEPTH   = 64,
    parameter int WAIT_CYCLES = 2,
    parameter int SPLIT_BASE  = 48,
    parameter int SPLIT_LAT   = 6
) (
    input  wire logic            clk,
    input  wire logic            rst,
    bus_slave_responder_if.slave bus
);

    localparam int               c_IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_W:0]  c_DEPTH     = (ADDR_W+1)'(MEM_DEPTH);
    localparam logic [ADDR_W:0]  c_SBASE     = (ADDR_W+1)'(SPLIT_BASE);
    localparam logic [3:0]       c_WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic [7:0]       c_SPLIT_LAT = 8'(SPLIT_LAT);
    localparam logic [1:0]       c_OKAY      = 2'b00;
    localparam logic [1:0]       c_ERROR     = 2'b01;
    localparam logic [1:0]       c_RETRY     = 2'b10;
    localparam logic [1:0]       c_SPLIT     = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_WAIT = 4'd1,
        S_DONE = 4'd2,
        S_ERR1 = 4'd3,
        S_ERR2 = 4'd4,
        S_SPL1 = 4'd5,
        S_SPL2 = 4'd6,
        S_RTY1 = 4'd7,
        S_RTY2 = 4'd8
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_wcnt;
    logic [3:0]          w_wcnt_nxt;
    logic [7:0]          r_scnt;
    logic                r_pend;
    logic                r_owner;
    logic [ADDR_W-1:0]   r_spl_addr;
    logic [c_IDX_W-1:0]  r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_rw;
    logic                r_ready;
    logic [1:0]          r_resp;
    logic                r_split;
    logic                r_split_master;
    logic [DATA_W-1:0]   r_rdata;
    logic [DATA_W-1:0]   r_mem [MEM_DEPTH];

    logic                w_take;
    logic                w_spl_start;
    logic                w_pend_clr;
    logic                w_ready_nxt;
    logic [1:0]          w_resp_nxt;
    logic                w_oor;
    logic                w_slow;
    logic                w_owner_match;
    logic                w_release;
    logic                w_in_idle;
    logic [c_IDX_W-1:0]  w_idx;
    logic                w_acc_wr;
    logic [DATA_W-1:0]   w_acc_wdata;
    logic                w_done_nxt;

    assign w_oor         = ({1'b0, bus.addr} >= c_DEPTH);
    assign w_slow        = ({1'b0, bus.addr} >= c_SBASE);
    assign w_owner_match = (bus.master_id == r_owner) && (bus.addr == r_spl_addr);
    assign w_release     = r_pend && (r_scnt == 8'd1);

    // A zero-wait transfer reaches DONE straight from IDLE, so the access
    // must use the live bus fields rather than the latched copies.
    assign w_in_idle   = (r_state == S_IDLE);
    assign w_idx       = w_in_idle ? bus.addr[c_IDX_W-1:0] : r_addr;
    assign w_acc_wr    = w_in_idle ? bus.read_write : r_rw;
    assign w_acc_wdata = w_in_idle ? bus.wdata : r_wdata;
    assign w_done_nxt  = (w_state_nxt == S_DONE);

    always_comb begin
        w_state_nxt = r_state;
        w_wcnt_nxt  = r_wcnt;
        w_take      = 1'b0;
        w_spl_start = 1'b0;
        w_pend_clr  = 1'b0;
        w_ready_nxt = 1'b1;
        w_resp_nxt  = c_OKAY;
        case (r_state)
            S_IDLE: begin
                if (bus.sel) begin
                    if (w_oor) begin
                        w_state_nxt = S_ERR1;
                    end else if (r_pend && !w_owner_match) begin
                        w_state_nxt = S_RTY1;
                    end else if (w_slow && !r_pend) begin
                        w_state_nxt = S_SPL1;
                        w_spl_start = 1'b1;
                    end else begin
                        w_take     = 1'b1;
                        w_pend_clr = r_pend;
                        if (WAIT_CYCLES == 0) begin
                            w_state_nxt = S_DONE;
                        end else begin
                            w_state_nxt = S_WAIT;
                            w_wcnt_nxt  = c_WAIT_INIT;
                        end
                    end
                end
            end
            S_WAIT: begin
                if (r_wcnt == 4'd0) w_state_nxt = S_DONE;
                else                w_wcnt_nxt  = r_wcnt - 4'd1;
            end
            S_ERR1:  w_state_nxt = S_ERR2;
            S_SPL1:  w_state_nxt = S_SPL2;
            S_RTY1:  w_state_nxt = S_RTY2;
            default: w_state_nxt = S_IDLE;
        endcase

        case (w_state_nxt)
            S_WAIT:  begin w_ready_nxt = 1'b0; w_resp_nxt = c_OKAY;  end
            S_ERR1:  begin w_ready_nxt = 1'b0; w_resp_nxt = c_ERROR; end
            S_ERR2:  begin w_ready_nxt = 1'b1; w_resp_nxt = c_ERROR; end
            S_SPL1:  begin w_ready_nxt = 1'b0; w_resp_nxt = c_SPLIT; end
            S_SPL2:  begin w_ready_nxt = 1'b1; w_resp_nxt = c_SPLIT; end
            S_RTY1:  begin w_ready_nxt = 1'b0; w_resp_nxt = c_RETRY; end
            S_RTY2:  begin w_ready_nxt = 1'b1; w_resp_nxt = c_RETRY; end
            default: begin w_ready_nxt = 1'b1; w_resp_nxt = c_OKAY;  end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_wcnt  <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_wcnt  <= w_wcnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_scnt         <= 8'd0;
            r_pend         <= 1'b0;
            r_owner        <= 1'b0;
            r_spl_addr     <= '0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_rw           <= 1'b0;
            r_ready        <= 1'b1;
            r_resp         <= c_OKAY;
            r_split        <= 1'b0;
            r_split_master <= 1'b0;
            r_rdata        <= '0;
        end else begin
            r_ready <= w_ready_nxt;
            r_resp  <= w_resp_nxt;
            r_split <= w_release;
            if (w_release) r_split_master <= r_owner;
            if (w_take) begin
                r_addr  <= bus.addr[c_IDX_W-1:0];
                r_wdata <= bus.wdata;
                r_rw    <= bus.read_write;
            end
            if (w_done_nxt && !w_acc_wr) r_rdata <= r_mem[w_idx];
            // Counter parks at zero after release until the owner re-issues.
            if (w_spl_start) begin
                r_pend     <= 1'b1;
                r_owner    <= bus.master_id;
                r_spl_addr <= bus.addr;
                r_scnt     <= c_SPLIT_LAT;
            end else if (w_pend_clr) begin
                r_pend <= 1'b0;
                r_scnt <= 8'd0;
            end else if (r_pend && (r_scnt != 8'd0)) begin
                r_scnt <= r_scnt - 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst && w_done_nxt && w_acc_wr) r_mem[w_idx] <= w_acc_wdata;
    end

    assign bus.ready        = r_ready;
    assign bus.response     = r_resp;
    assign bus.split        = r_split;
    assign bus.split_master = r_split_master;
    assign bus.rdata        = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_bus_slave_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_slave_responder
// Brief    : Directed scoreboard bench for a WAIT_CYCLES=2 and a WAIT_CYCLES=0 slave.
// Revision : 1.0
// ============================================================================
module tb_bus_slave_responder;

    logic clk;
    logic rst;

    bus_slave_responder_if #(.ADDR_W(8), .DATA_W(8)) bus0 ();
    bus_slave_responder_if #(.ADDR_W(8), .DATA_W(8)) bus1 ();

    bus_slave_responder #(
        .ADDR_W(8), .DATA_W(8), .MEM_DEPTH(64), .WAIT_CYCLES(2), .SPLIT_BASE(48), .SPLIT_LAT(6)
    ) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    bus_slave_responder #(
        .ADDR_W(8), .DATA_W(8), .MEM_DEPTH(64), .WAIT_CYCLES(0), .SPLIT_BASE(48), .SPLIT_LAT(6)
    ) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         d;
        string      tag;
        logic       rdy;
        logic [1:0] rsp;
        logic       spl;
        logic       sm;
        logic       chk_rd;
        logic [7:0] rd;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    logic sm_exp = 1'b0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(int d, string tag, logic rdy, logic [1:0] rsp, logic spl,
                        logic chk_rd, logic [7:0] rd);
        exp_t e;
        e.d      = d;
        e.tag    = tag;
        e.rdy    = rdy;
        e.rsp    = rsp;
        e.spl    = spl;
        e.sm     = (d == 0) ? sm_exp : 1'b0;
        e.chk_rd = chk_rd;
        e.rd     = rd;
        sb.push_back(e);
    endtask

    task automatic issue(int d, logic mid, logic rw, logic [7:0] a, logic [7:0] wd);
        if (d == 0) begin
            bus0.sel = 1'b1; bus0.master_id = mid; bus0.read_write = rw;
            bus0.addr = a;   bus0.wdata = wd;
        end else begin
            bus1.sel = 1'b1; bus1.master_id = mid; bus1.read_write = rw;
            bus1.addr = a;   bus1.wdata = wd;
        end
    endtask

    // One queued expectation per clock; sel is dropped after its sampling edge.
    task automatic drain();
        exp_t       e;
        logic       rdy, spl, sm;
        logic [1:0] rsp;
        logic [7:0] rd;
        while (sb.size() > 0) begin
            step();
            bus0.sel = 1'b0;
            bus1.sel = 1'b0;
            e = sb.pop_front();
            if (e.d == 0) begin
                rdy = bus0.ready; rsp = bus0.response; spl = bus0.split;
                sm  = bus0.split_master; rd = bus0.rdata;
            end else begin
                rdy = bus1.ready; rsp = bus1.response; spl = bus1.split;
                sm  = bus1.split_master; rd = bus1.rdata;
            end
            chk({e.tag, ".ready"}, {7'd0, rdy}, {7'd0, e.rdy});
            chk({e.tag, ".resp"},  {6'd0, rsp}, {6'd0, e.rsp});
            chk({e.tag, ".split"}, {7'd0, spl}, {7'd0, e.spl});
            chk({e.tag, ".split_master"}, {7'd0, sm}, {7'd0, e.sm});
            if (e.chk_rd) chk({e.tag, ".rdata"}, rd, e.rd);
        end
    endtask

    task automatic okay_seq(int d, string tag, logic is_rd, logic [7:0] rd);
        int nw;
        nw = (d == 0) ? 2 : 0;
        for (int i = 0; i < nw; i++) push(d, {tag, ".wait"}, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00);
        push(d, {tag, ".done"}, 1'b1, 2'b00, 1'b0, is_rd, rd);
        push(d, {tag, ".idle"}, 1'b1, 2'b00, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic two_seq(int d, string tag, logic [1:0] rsp);
        push(d, {tag, ".p1"},   1'b0, rsp,   1'b0, 1'b0, 8'h00);
        push(d, {tag, ".p2"},   1'b1, rsp,   1'b0, 1'b0, 8'h00);
        push(d, {tag, ".idle"}, 1'b1, 2'b00, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        rst = 1'b0;
        bus0.sel = 1'b0; bus0.master_id = 1'b0; bus0.read_write = 1'b0; bus0.addr = '0; bus0.wdata = '0;
        bus1.sel = 1'b0; bus1.master_id = 1'b0; bus1.read_write = 1'b0; bus1.addr = '0; bus1.wdata = '0;
        step();
        step();
        chk("rst0.ready", {7'd0, bus0.ready}, 8'd1);
        chk("rst0.resp",  {6'd0, bus0.response}, 8'd0);
        chk("rst0.split", {7'd0, bus0.split}, 8'd0);
        chk("rst0.split_master", {7'd0, bus0.split_master}, 8'd0);
        chk("rst0.rdata", bus0.rdata, 8'h00);
        chk("rst1.ready", {7'd0, bus1.ready}, 8'd1);
        chk("rst1.resp",  {6'd0, bus1.response}, 8'd0);
        chk("rst1.rdata", bus1.rdata, 8'h00);
        rst = 1'b1;

        issue(0, 1'b0, 1'b1, 8'd5, 8'hA5);  okay_seq(0, "wr5", 1'b0, 8'h00); drain();
        issue(0, 1'b0, 1'b0, 8'd5, 8'h00);  okay_seq(0, "rd5", 1'b1, 8'hA5); drain();
        issue(0, 1'b0, 1'b1, 8'd6, 8'h66);  okay_seq(0, "wr6", 1'b0, 8'h00); drain();
        issue(0, 1'b0, 1'b1, 8'd3, 8'h33);  okay_seq(0, "wr3", 1'b0, 8'h00); drain();
        issue(0, 1'b0, 1'b1, 8'd70, 8'hEE); two_seq(0, "oor_wr", 2'b01);     drain();
        issue(0, 1'b0, 1'b0, 8'd70, 8'h00); two_seq(0, "oor_rd", 2'b01);     drain();
        issue(0, 1'b0, 1'b0, 8'd6, 8'h00);  okay_seq(0, "rd6", 1'b1, 8'h66); drain();

        // First split: owner master 0, release six edges after SPL1 entry.
        issue(0, 1'b0, 1'b1, 8'd50, 8'h5A); two_seq(0, "spl_a", 2'b11); drain();
        issue(0, 1'b1, 1'b1, 8'd3, 8'h99);  two_seq(0, "rty_a", 2'b10); drain();
        push(0, "rel_a", 1'b1, 2'b00, 1'b1, 1'b0, 8'h00);
        push(0, "rel_a_after", 1'b1, 2'b00, 1'b0, 1'b0, 8'h00);
        drain();
        issue(0, 1'b0, 1'b1, 8'd50, 8'h5A); okay_seq(0, "reiss_a", 1'b0, 8'h00); drain();
        issue(0, 1'b1, 1'b0, 8'd3, 8'h00);  okay_seq(0, "rd3_kept", 1'b1, 8'h33); drain();
        issue(0, 1'b1, 1'b1, 8'd3, 8'h99);  okay_seq(0, "wr3_ok", 1'b0, 8'h00);   drain();
        issue(0, 1'b1, 1'b0, 8'd3, 8'h00);  okay_seq(0, "rd3_new", 1'b1, 8'h99);  drain();

        // Second split: owner master 1; re-issue sampled on the release edge.
        issue(0, 1'b1, 1'b0, 8'd50, 8'h00); two_seq(0, "spl_b", 2'b11); drain();
        issue(0, 1'b0, 1'b0, 8'd50, 8'h00); two_seq(0, "rty_b", 2'b10); drain();
        issue(0, 1'b1, 1'b0, 8'd50, 8'h00);
        sm_exp = 1'b1;
        push(0, "reiss_b.w1",   1'b0, 2'b00, 1'b1, 1'b0, 8'h00);
        push(0, "reiss_b.w2",   1'b0, 2'b00, 1'b0, 1'b0, 8'h00);
        push(0, "reiss_b.done", 1'b1, 2'b00, 1'b0, 1'b1, 8'h5A);
        push(0, "reiss_b.idle", 1'b1, 2'b00, 1'b0, 1'b0, 8'h00);
        drain();

        // Reset during WAIT abandons the write to address 7.
        issue(0, 1'b0, 1'b1, 8'd7, 8'h77); okay_seq(0, "wr7", 1'b0, 8'h00); drain();
        issue(0, 1'b0, 1'b1, 8'd7, 8'h3C);
        push(0, "wr7b.wait", 1'b0, 2'b00, 1'b0, 1'b0, 8'h00);
        drain();
        rst = 1'b0;
        sm_exp = 1'b0;
        push(0, "rst_mid", 1'b1, 2'b00, 1'b0, 1'b1, 8'h00);
        drain();
        rst = 1'b1;
        push(0, "post_rst", 1'b1, 2'b00, 1'b0, 1'b1, 8'h00);
        drain();
        issue(0, 1'b0, 1'b0, 8'd7, 8'h00); okay_seq(0, "rd7", 1'b1, 8'h77); drain();

        // Zero-wait instance.
        issue(1, 1'b0, 1'b1, 8'd0, 8'h11); okay_seq(1, "w0_wr", 1'b0, 8'h00); drain();
        issue(1, 1'b0, 1'b0, 8'd0, 8'h00); okay_seq(1, "w0_rd", 1'b1, 8'h11); drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
